mips_fetch_stage: RTL

//  Instruction-fetch stage between the PC register and decode. Fetches from a

---
 rtl/mips_fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: req/ack instruction memory front end feeding IF/ID,
// with PC_WRITE back-pressure, decode-stall buffering and redirect kill of in-flight fetches.
module mips_fetch_stage #(
    parameter int              AW  = 32,
    parameter int              DW  = 32,
    parameter logic [DW-1:0]   NOP = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] NPC,
    input  logic          ID_STALL,
    input  logic          FLUSH,
    output logic          PC_WRITE,
    output logic          IMEM_REQ,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic          IMEM_ACK,
    input  logic [DW-1:0] IMEM_RDATA,
    output logic [AW-1:0] IFID_PC4,
    output logic [DW-1:0] IFID_INSTR,
    output logic          IFID_VALID
);
    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, pend_q, pend_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          deliver;
    logic [DW-1:0] deliver_data;
    logic          pc_write_raw;

    assign IMEM_ADDR = addr_q;
    assign PC_WRITE  = pc_write_raw & ~RESET;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        pc_write_raw = 1'b0;
        deliver      = 1'b0;
        deliver_data = hold_q;
        IMEM_REQ     = 1'b0;
        case (state_q)
            S_WAIT: begin
                IMEM_REQ = 1'b1;
                if (FLUSH) begin
                    pc_write_raw = 1'b1;
                    if (IMEM_ACK) begin
                        addr_d = NPC;
                    end else begin
                        // request stays on the bus; remember where to go once it drains
                        pend_d  = NPC;
                        state_d = S_DROP;
                    end
                end else if (IMEM_ACK) begin
                    if (!ID_STALL) begin
                        deliver      = 1'b1;
                        deliver_data = IMEM_RDATA;
                        pc_write_raw = 1'b1;
                        addr_d       = NPC;
                    end else begin
                        hold_d  = IMEM_RDATA;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (FLUSH) begin
                    pc_write_raw = 1'b1;
                    addr_d       = NPC;
                    state_d      = S_WAIT;
                end else if (!ID_STALL) begin
                    deliver      = 1'b1;
                    pc_write_raw = 1'b1;
                    addr_d       = NPC;
                    state_d      = S_WAIT;
                end
            end
            S_DROP: begin
                IMEM_REQ = 1'b1;
                if (FLUSH) begin
                    pc_write_raw = 1'b1;
                    pend_d       = NPC;
                end
                if (IMEM_ACK) begin
                    addr_d  = FLUSH ? NPC : pend_q;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_WAIT;
            addr_q     <= '0;
            pend_q     <= '0;
            hold_q     <= '0;
            IFID_PC4   <= '0;
            IFID_INSTR <= NOP;
            IFID_VALID <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            if (FLUSH) begin
                IFID_VALID <= 1'b0;
                IFID_INSTR <= NOP;
            end else if (!ID_STALL) begin
                if (deliver) begin
                    IFID_PC4   <= addr_q + AW'(4);
                    IFID_INSTR <= deliver_data;
                    IFID_VALID <= 1'b1;
                end else begin
                    IFID_VALID <= 1'b0;
                    IFID_INSTR <= NOP;
                end
            end
        end
    end
endmodule
